// File: rtl/tdc_packetizer.sv
// -----------------------------------------------------------------------------
// tdc_packetizer
//
// Sits in front of the byte-serial UART transmitter. TDC measurement words are
// queued in a small FIFO and each one is sent as a frame:
//
//    SYNC, data byte 0 (MSB) .. data byte NB-1 (LSB), XOR checksum
//
// NB = ceil(WIDTH/8). When WIDTH is not a multiple of 8, the top byte is
// zero-padded. The checksum covers the data bytes only.
//
// The transmitter keeps reading axi_data while it serialises a byte. After a
// transfer, the FSM therefore parks in HOLD with axi_valid low and axi_data
// frozen. It moves on only when it samples axi_ready high again, which means
// the transmitter has finished shifting the previous byte out.
//
// Ports
//    clk           clock
//    rst           asynchronous, active-high reset
//    meas_valid    one-cycle strobe qualifying meas_data (no backpressure)
//    meas_data     measurement word, WIDTH bits
//    axi_valid     byte available to the transmitter
//    axi_ready     transmitter idle and able to take a byte
//    axi_data      byte to transmit
//    fifo_level    words currently queued (0..DEPTH)
//    overflow_cnt  measurements dropped because the FIFO was full (saturates)
// -----------------------------------------------------------------------------
module tdc_packetizer #(
   parameter int         WIDTH = 16,
   parameter int         DEPTH = 4,
   parameter logic [7:0] SYNC  = 8'hA5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     meas_valid,
   input  logic [WIDTH-1:0]         meas_data,
   output logic                     axi_valid,
   input  logic                     axi_ready,
   output logic [7:0]               axi_data,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic [7:0]               overflow_cnt
);

   localparam int NB = (WIDTH + 7) / 8;     // data bytes per frame
   localparam int PW = NB * 8;              // padded word width
   localparam int AW = $clog2(DEPTH);       // FIFO pointer width
   localparam int LW = AW + 1;              // FIFO level width
   localparam int IW = $clog2(NB + 2);      // byte index width, counts 0..NB+1

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      HOLD
   } state_t;

   // ---------------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             drop;

   assign full  = (fifo_level == LW'(DEPTH));
   assign empty = (fifo_level == '0);

   // A pop in the same cycle frees a slot, so a push into a full FIFO is
   // still accepted then. The write and read slots can coincide in that
   // case. The frame register captures the old head before the new word
   // lands.
   assign push = meas_valid && (!full || pop);
   assign drop = meas_valid && full && !pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= meas_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level   <= '0;
         overflow_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (drop && overflow_cnt != 8'hFF) begin
            overflow_cnt <= overflow_cnt + 8'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Framing FSM
   //
   // idx counts the bytes presented after SYNC:
   //    idx < NB   -> next byte is data byte idx
   //    idx == NB  -> next byte is the checksum
   //    idx == NB+1 -> the checksum has gone, and the frame is done
   //
   // The frame register is shifted left one byte each time a data byte is
   // presented, so the next data byte is always its top byte. This works for
   // any NB without a variable part-select.
   // ---------------------------------------------------------------------------
   state_t         state;
   state_t         state_n;
   logic [IW-1:0]  idx;
   logic [IW-1:0]  idx_n;
   logic [7:0]     csum;
   logic [7:0]     csum_n;
   logic [PW-1:0]  frame;
   logic [PW-1:0]  frame_n;
   logic           valid_n;
   logic [7:0]     data_n;
   logic [7:0]     top_byte;

   assign top_byte = frame[PW-1 -: 8];

   always_comb begin
      state_n = state;
      valid_n = axi_valid;
      data_n  = axi_data;
      idx_n   = idx;
      csum_n  = csum;
      frame_n = frame;
      pop     = 1'b0;

      case (state)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               frame_n = PW'(mem[rd_ptr]);
               data_n  = SYNC;
               valid_n = 1'b1;
               idx_n   = '0;
               csum_n  = '0;
               state_n = SEND;
            end
         end

         SEND: begin
            if (axi_ready) begin
               valid_n = 1'b0;
               state_n = HOLD;
            end
         end

         HOLD: begin
            // axi_ready high here means the previous byte has been fully
            // serialised, so axi_data can now change.
            if (axi_ready) begin
               if (idx == IW'(NB + 1)) begin
                  state_n = IDLE;
               end else if (idx == IW'(NB)) begin
                  data_n  = csum;
                  valid_n = 1'b1;
                  idx_n   = idx + IW'(1);
                  state_n = SEND;
               end else begin
                  data_n  = top_byte;
                  csum_n  = csum ^ top_byte;
                  frame_n = frame << 8;
                  valid_n = 1'b1;
                  idx_n   = idx + IW'(1);
                  state_n = SEND;
               end
            end
         end

         default: begin
            state_n = IDLE;
            valid_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         axi_valid <= 1'b0;
         axi_data  <= '0;
         idx       <= '0;
         csum      <= '0;
         frame     <= '0;
      end else begin
         state     <= state_n;
         axi_valid <= valid_n;
         axi_data  <= data_n;
         idx       <= idx_n;
         csum      <= csum_n;
         frame     <= frame_n;
      end
   end

endmodule

// File: tb/tb_tdc_packetizer.sv
// -----------------------------------------------------------------------------
// tb_tdc_packetizer
//
// Main DUT: WIDTH=16, DEPTH=4. It is checked every cycle against a queue-based
// scoreboard, and a behavioural transmitter drives axi_ready.
//
// Second DUT: WIDTH=12. It is used for the zero-padding frames.
//
// All sampling happens on the falling edge. A transfer is predicted at the
// falling edge before the rising edge that performs it. Model updates for a
// rising edge are applied at the falling edge that follows it.
// -----------------------------------------------------------------------------
module tb_tdc_packetizer;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int NB    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        meas_valid = 1'b0;
   logic [15:0] meas_data = '0;
   logic        axi_ready = 1'b0;
   logic        axi_valid;
   logic [7:0]  axi_data;
   logic [2:0]  fifo_level;
   logic [7:0]  overflow_cnt;

   logic        p_meas_valid = 1'b0;
   logic [11:0] p_meas_data = '0;
   logic        p_ready = 1'b1;
   logic        p_valid;
   logic [7:0]  p_data;
   logic [2:0]  p_level;
   logic [7:0]  p_ovf;

   always #5 clk = ~clk;

   tdc_packetizer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC(8'hA5)) u_dut (
      .clk(clk), .rst(rst), .meas_valid(meas_valid), .meas_data(meas_data),
      .axi_valid(axi_valid), .axi_ready(axi_ready), .axi_data(axi_data),
      .fifo_level(fifo_level), .overflow_cnt(overflow_cnt)
   );

   tdc_packetizer #(.WIDTH(12), .DEPTH(DEPTH), .SYNC(8'hA5)) u_pad (
      .clk(clk), .rst(rst), .meas_valid(p_meas_valid), .meas_data(p_meas_data),
      .axi_valid(p_valid), .axi_ready(p_ready), .axi_data(p_data),
      .fifo_level(p_level), .overflow_cnt(p_ovf)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected byte at position p of a frame carrying word w.
   function automatic logic [7:0] exp_byte(input logic [31:0] w, input int nb, input int p);
      logic [7:0] x;
      x = 8'h00;
      if (p == 0) return 8'hA5;
      if (p <= nb) return 8'((w >> ((nb - p) * 8)) & 32'hFF);
      for (int k = 0; k < nb; k++) x = x ^ 8'((w >> (k * 8)) & 32'hFF);
      return x;
   endfunction

   // ---------------------------------------------------------------------------
   // Scoreboard and transmitter model state
   // ---------------------------------------------------------------------------
   logic [15:0] q[$];
   logic [7:0]  rx[$];
   int          m_cnt = 0;
   logic [15:0] cur_word = '0;
   int          pos = 0;
   bit          frame_active = 0;
   bit          locked = 0;
   logic [7:0]  lock_data = '0;
   bit          pend_rel = 0;
   bit          was_sending = 0;
   bit          prev_xfer = 0;
   int          busy = 0;
   int          busy_len = 9;
   bit          stall = 0;
   bit          rand_mode = 0;
   bit          push_pend = 0;
   logic [15:0] push_word = '0;
   int          frames_done = 0;
   int          pops = 0;
   int          lvl_before;
   bit          popped;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            m_cnt = 0; pos = 0; frame_active = 0; locked = 0; pend_rel = 0;
            was_sending = 0; prev_xfer = 0; busy = 0; push_pend = 0;
            axi_ready = stall ? 1'b0 : 1'b1;
            continue;
         end
         // A frame start (pop) is visible as axi_valid rising outside a frame.
         popped = 0;
         lvl_before = q.size();
         if (axi_valid && !frame_active) begin
            chk("pop_from_nonempty", 32'(lvl_before != 0), 1);
            if (q.size() > 0) cur_word = q.pop_front();
            popped = 1; frame_active = 1; pos = 0; pops++;
         end
         if (push_pend) begin
            if (lvl_before < DEPTH || popped) q.push_back(push_word);
            else if (m_cnt < 255) m_cnt++;
         end
         push_pend = meas_valid;
         push_word = meas_data;
         chk("fifo_level", 32'(fifo_level), 32'(q.size()));
         chk("overflow_cnt", 32'(overflow_cnt), 32'(m_cnt));
         if (locked) chk("hold_data", 32'(axi_data), 32'(lock_data));
         if (was_sending) chk("valid_held", 32'(axi_valid), 1);
         if (prev_xfer) chk("valid_drop", 32'(axi_valid), 0);
         if (axi_valid) begin
            chk("valid_before_ready", 32'(pend_rel), 0);
            if (!locked) begin locked = 1; lock_data = axi_data; end
         end
         // Transmitter ready for the coming rising edge.
         if (stall) axi_ready = 1'b0;
         else if (busy > 0) begin axi_ready = 1'b0; busy--; end
         else if (rand_mode && $urandom_range(0, 3) == 0) axi_ready = 1'b0;
         else axi_ready = 1'b1;
         if (pend_rel && axi_ready) begin pend_rel = 0; locked = 0; end
         prev_xfer = 0;
         was_sending = axi_valid;
         if (axi_valid && axi_ready) begin
            chk("byte", 32'(axi_data), 32'(exp_byte(32'(cur_word), NB, pos)));
            rx.push_back(axi_data);
            pos++;
            if (pos == NB + 2) begin pos = 0; frame_active = 0; frames_done++; end
            pend_rel = 1; prev_xfer = 1; was_sending = 0;
            busy = rand_mode ? int'($urandom_range(0, 4)) : busy_len;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic sample();
      @(negedge clk); #1;
   endtask

   // Call at a rising edge + 1.
   task automatic push(input logic [15:0] w);
      meas_valid = 1'b1; meas_data = w;
      @(posedge clk); #1;
      meas_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int c;
      c = 0;
      while (frames_done < target && c < budget) begin sample(); c++; end
      chk("frame_timeout", 32'(frames_done >= target), 1);
   endtask

   task automatic wait_drain(input int budget);
      int c;
      c = 0;
      while ((q.size() != 0 || frame_active) && c < budget) begin sample(); c++; end
      chk("drain_timeout", 32'(q.size() == 0 && !frame_active), 1);
      repeat (busy_len + 6) sample();
      chk("drain_level", 32'(fifo_level), 0);
   endtask

   // The first word is popped and stuck in SEND while ready is low. The
   // next four fill the FIFO.
   task automatic fill_stuck();
      stall = 1;
      @(posedge clk); #1;
      push(16'($urandom));
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) push(16'($urandom));
   endtask

   task automatic pad_frame(input logic [11:0] w, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] got[$];
      logic [7:0] exp[4];
      exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
      @(posedge clk); #1;
      p_meas_valid = 1'b1; p_meas_data = w;
      @(posedge clk); #1;
      p_meas_valid = 1'b0;
      for (int c = 0; c < 40 && got.size() < 4; c++) begin
         sample();
         if (p_valid && p_ready) got.push_back(p_data);
      end
      chk("pad_len", 32'(got.size()), 4);
      for (int i = 0; i < 4; i++)
         chk("pad_byte", (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp[i]));
      repeat (4) sample();
   endtask

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      int f0, c0, p0, n0, s0, c;
      logic [7:0] e1[4];

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      sample();
      chk("rst_valid", 32'(axi_valid), 0);
      chk("rst_data", 32'(axi_data), 0);
      chk("rst_level", 32'(fifo_level), 0);
      chk("rst_ovf", 32'(overflow_cnt), 0);

      // Single frame, 9-cycle transmitter busy time, latency check.
      busy_len = 9;
      @(posedge clk); #1;
      rx.delete();
      f0 = frames_done;
      push(16'h1234);
      sample();
      chk("latency_early", 32'(axi_valid), 0);
      sample();
      chk("latency", 32'(axi_valid), 1);
      wait_frames(f0 + 1, 200);
      e1[0] = 8'hA5; e1[1] = 8'h12; e1[2] = 8'h34; e1[3] = 8'h26;
      chk("single_len", 32'(rx.size()), 4);
      for (int i = 0; i < 4; i++)
         chk("single_byte", (i < rx.size()) ? 32'(rx[i]) : 32'hDEAD, 32'(e1[i]));
      repeat (busy_len + 6) sample();

      // Zero padding on the 12-bit instance.
      pad_frame(12'hABC, 8'hA5, 8'h0A, 8'hBC, 8'hB6);
      pad_frame(12'hFFF, 8'hA5, 8'h0F, 8'hFF, 8'hF0);

      // Overflow: one frame stuck in SEND, then words 1..6 back to back.
      stall = 1;
      @(posedge clk); #1;
      push(16'h00FF);
      repeat (3) @(posedge clk);
      #1;
      for (int i = 1; i <= 6; i++) push(16'(i));
      sample();
      chk("ovf_level", 32'(fifo_level), 4);
      chk("ovf_cnt", 32'(overflow_cnt), 2);
      rx.delete();
      f0 = frames_done;
      stall = 0;
      wait_frames(f0 + 5, 600);
      chk("ovf_rx_len", 32'(rx.size()), 20);
      for (int k = 1; k <= 4; k++)
         chk("ovf_word", (rx.size() >= 20) ? {16'h0, rx[4*k+1], rx[4*k+2]} : 32'hDEAD, 32'(k));
      wait_drain(400);

      // FIFO kept full with meas_valid held high; only pop cycles accept.
      fill_stuck();
      sample();
      chk("full_level", 32'(fifo_level), 4);
      c0 = m_cnt;
      p0 = pops;
      stall = 0;
      @(posedge clk); #1;
      meas_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         meas_data = 16'($urandom);
         @(posedge clk); #1;
      end
      meas_valid = 1'b0;
      sample();
      chk("simul_level", 32'(fifo_level), 4);
      chk("simul_cnt", 32'(overflow_cnt), 32'(c0 + 60 - (pops - p0)));
      chk("simul_popped", 32'(pops - p0 > 0), 1);
      wait_drain(600);

      // Saturation of the drop counter.
      fill_stuck();
      meas_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         meas_data = 16'($urandom);
         @(posedge clk); #1;
      end
      meas_valid = 1'b0;
      sample();
      chk("sat_cnt", 32'(overflow_cnt), 255);
      chk("sat_level", 32'(fifo_level), 4);
      stall = 0;
      wait_drain(800);

      // Reset just after the SYNC byte has been taken.
      stall = 1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) push(16'h5A00 + 16'(i));
      stall = 0;
      c = 0;
      while (pos < 1 && c < 200) begin sample(); c++; end
      chk("sync_seen", 32'(pos), 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(axi_valid), 0);
      chk("arst_data", 32'(axi_data), 0);
      chk("arst_level", 32'(fifo_level), 0);
      chk("arst_ovf", 32'(overflow_cnt), 0);
      repeat (2) @(negedge clk);
      #3 rst = 1'b0;
      n0 = rx.size();
      repeat (20) sample();
      chk("no_bytes_after_rst", 32'(rx.size()), 32'(n0));
      f0 = frames_done;
      s0 = rx.size();
      @(posedge clk); #1;
      push(16'hC0DE);
      wait_frames(f0 + 1, 200);
      chk("fresh_len", 32'(rx.size() - s0), 4);
      chk("fresh_sync", (rx.size() > s0) ? 32'(rx[s0]) : 32'hDEAD, 32'hA5);
      repeat (busy_len + 6) sample();

      // Random traffic against the scoreboard.
      rand_mode = 1;
      @(posedge clk); #1;
      for (int i = 0; i < 1500; i++) begin
         meas_valid = ($urandom_range(0, 9) == 0);
         meas_data  = 16'($urandom);
         @(posedge clk); #1;
      end
      meas_valid = 1'b0;
      rand_mode = 0;
      busy_len = 1;
      wait_drain(3000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tdc_packetizer.md
Name: tdc_packetizer

Overview:
- Stage directly upstream of the byte-serial UART transmitter.
- Buffers TDC measurement words in a small FIFO and emits each as a framed byte stream: sync byte, measurement bytes MSB-first, XOR checksum byte.
- Drives the transmitter's valid/ready/data byte interface.
- Holds each byte stable for as long as the transmitter is still serialising it.

Parameters:
- WIDTH, 16, measurement word width in bits. Range 1..32. NB = ceil(WIDTH/8) data bytes per frame; unused MSBs of the top byte are zero-padded.
- DEPTH, 4, FIFO depth in words. Power of two, at least 2.
- SYNC, 8'hA5, frame sync byte.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- meas_valid  in  1  single-cycle strobe; meas_data is valid this cycle. There is no backpressure on this input.
- meas_data  in  WIDTH  measurement word.
- axi_valid  out  1  byte available to the transmitter.
- axi_ready  in  1  transmitter idle and able to accept a byte.
- axi_data  out  8  byte to transmit.
- fifo_level  out  $clog2(DEPTH)+1  number of words currently queued.
- overflow_cnt  out  8  count of dropped measurements; saturates at 255.

Behaviour:
- Reset: asynchronous and active-high; takes effect immediately. On reset: axi_valid=0, axi_data=0, fifo_level=0, overflow_cnt=0, FSM=IDLE. Any partial frame is discarded, with no resumption after reset.
- Transfer: occurs at a posedge where axi_valid=1 and axi_ready=1.
- Hold rule: from assertion of axi_valid until the first posedge after the transfer at which axi_ready=1 is sampled, axi_data must not change. The transmitter reads axi_data throughout serialisation.
- Valid rule: once asserted, axi_valid stays high until the transfer. It deasserts on the transfer edge.
- FIFO push: meas_valid=1 and level<DEPTH. The word is written and level increments.
- FIFO overflow: meas_valid=1 with level==DEPTH. The word is dropped and overflow_cnt increments (saturating at 255).
- FIFO pop: occurs only in IDLE when level>0. The head word moves into the frame register.
- Push and pop in the same cycle: both take effect and level is unchanged. A push when level==DEPTH and a pop occurs in the same cycle is accepted, not dropped.
- FSM states:
  - IDLE: if level>0, pop; axi_data<=SYNC, axi_valid<=1, byte index<=0, checksum<=0; go to SEND.
  - SEND: axi_valid=1. On transfer: axi_valid<=0; go to HOLD.
  - HOLD: axi_valid=0, axi_data held. When axi_ready=1 is sampled, present the next byte: data byte k (MSB-first, k=0..NB-1) with checksum^=byte, then the checksum byte. Set axi_valid<=1 and go to SEND. If the checksum byte was just transferred, go to IDLE instead.
- Frame length: NB+2 bytes.
- Checksum: XOR of the NB data bytes only. SYNC is excluded.
- Latency: at least one idle cycle between frames. First axi_valid=1 is 2 cycles after a meas_valid into an empty FIFO with FSM in IDLE (push cycle, then pop cycle).
- axi_ready may be high or low at any time. The block never presents a byte without first seeing axi_ready=1 after the previous transfer.
- fifo_level and overflow_cnt are registered and update on the edge of the push or drop.

Test Plan:
- Single frame: WIDTH=16, one meas_valid with 16'h1234, transmitter model accepts each byte then holds axi_ready=0 for 9 cycles -> bytes A5,12,34,26 in order. axi_data is stable during every ready-low window and axi_valid=0 during HOLD.
- Padding: WIDTH=12, meas_data=12'hABC -> bytes A5,0A,BC,B6.
- Overflow: DEPTH=4, 6 back-to-back meas_valid (1..6) while axi_ready=0 -> fifo_level=4, overflow_cnt=2. After release, 4 frames are emitted carrying 1,2,3,4.
- Simultaneous push/pop: FIFO full while FSM in IDLE with axi_ready=1, and meas_valid=1 -> word accepted, overflow_cnt unchanged, level stays 4.
- Saturation: 300 drops -> overflow_cnt=255.
- Reset mid-frame: assert rst after the SYNC byte transfer -> axi_valid=0 and fifo_level=0 immediately, with no further bytes. A new measurement then produces a complete fresh frame starting with A5.
